simon_seq: RTL
==============

Name: simon_seq

Overview:
Iterative SIMON32/64 engine and sequencer. It sits between the UART command FSM and the cipher datapath. It accepts the 8 key bytes, 4 text bytes and the encrypt/decrypt flag, expands the round keys into an internal key store, then runs 32 rounds forward (encrypt) or in reverse key order (decrypt). It raises result_ready and holds crypt_out until the next accepted start.

Parameters:
ROUNDS, 32, number of rounds; only 32 is legal for SIMON32/64.
KEY_CACHE, 1, 1 = skip key expansion when the key bytes equal those of the last completed expansion; 0 = always expand.

Ports:
clk  in  1  global clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle request; sampled only when busy=0
cryp_decryp  in  1  1 = encrypt, 0 = decrypt; sampled with start
k_in  in  8x8 (unpacked [7:0])  key bytes; key word kj = {k_in[2j+1], k_in[2j]}, k0 is the first round key
text_in  in  4x8 (unpacked [3:0])  block; x = {text_in[3], text_in[2]}, y = {text_in[1], text_in[0]}
crypt_out  out  4x8 (unpacked [3:0])  result, same packing as text_in
result_ready  out  1  level; result valid
busy  out  1  high in EXPAND and RUN

Behaviour:
- Reset values: crypt_out = 0, result_ready = 0, busy = 0, state = IDLE, key-cache valid flag = 0. Key store contents are don't-care.
- States: IDLE, EXPAND, RUN, DONE. busy = (state==EXPAND || state==RUN).
- Accepting start (IDLE or DONE, start=1):
  - Latch x, y, the direction and all 8 key bytes.
  - Clear result_ready at the same edge.
  - Write k0..k3 to key store entries 0..3.
- Next state after start:
  - RUN, if KEY_CACHE=1, the cache is valid and the latched key equals the previous key.
  - Otherwise EXPAND, with expansion index i = 4.
- start while busy is ignored with no side effect.
- EXPAND: one key per cycle. k[i] = 16'hFFFC ^ z[i-4] ^ k[i-4] ^ t ^ rotr1(t), where t = rotr3(k[i-1]) ^ k[i-3]. The bit z[j] = Z0[61-j].
  - Leave EXPAND after writing k[31], i.e. 28 cycles.
  - On exit, set cache valid to 1 and go to RUN.
- RUN: round counter rc starts at 0 (encrypt) or 31 (decrypt). It steps +1 or -1 per cycle for 32 cycles.
  - f(v) = (rotl1(v) & rotl8(v)) ^ rotl2(v).
  - Encrypt: x' = y ^ f(x) ^ k[rc]; y' = x.
  - Decrypt: x' = y; y' = x ^ f(y) ^ k[rc].
- Completing round 32 registers {x, y} into crypt_out, sets result_ready = 1 and goes to DONE.
- Latency from the start edge to result_ready high:
  - 60 cycles when expanding (28 + 32).
  - 32 cycles on a cache hit.
- DONE: result_ready and crypt_out are held stable indefinitely. The UART FSM reads them over many cycles. A new start is accepted as above.
- Reset mid-EXPAND or mid-RUN: immediate return to the reset values. The cache is invalidated, so a partial key store is never reused.
- All arithmetic is 16-bit, modulo rotations, with no carries.

Decomposition:
- Package simon_pkg:
  - Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110
  - C_CONST = 16'hFFFC
  - state enum {IDLE, EXPAND, RUN, DONE}
  - rotl16/rotr16 functions
- Sub-module simon_round: combinational round function. Inputs x, y, k and direction; outputs x', y'. It is instantiated once and reused every RUN cycle.
- The key store is a 32x16 register array local to simon_seq.

Test Plan:
1. Encrypt known-answer vector.
   - Stimulus: reset, then start with cryp_decryp=1. Key bytes k_in[7..0] = 19 18 11 10 09 08 01 00. Text bytes text_in[3..0] = 65 65 68 77.
   - Required response: result_ready rises 60 cycles after start, with crypt_out[3..0] = c6 9b e9 bb. busy is high for exactly 60 cycles.
2. Decrypt, same key (KEY_CACHE=1).
   - Stimulus: start with cryp_decryp=0 and text c6 9b e9 bb.
   - Required response: result_ready after 32 cycles (cache hit), crypt_out = 65 65 68 77.
3. Changed key forces re-expansion.
   - Stimulus: change k_in[0] to 01 and encrypt.
   - Required response: 60-cycle latency. Decrypting the result with the same key returns the plaintext.
4. Start while busy is ignored.
   - Stimulus: pulse start with different text at cycle 10 of RUN.
   - Required response: no effect; the output equals case 1's result and the latency is unchanged.
5. Reset mid-operation.
   - Stimulus: assert reset during EXPAND, then re-run case 2's decrypt without re-encrypting.
   - Required response: outputs are 0 immediately. The rerun takes 60 cycles (cache invalid) and still produces the correct plaintext.
6. Output holding and restart from DONE.
   - Stimulus: hold in DONE for 1000 cycles, then issue a new start.
   - Required response: crypt_out and result_ready are stable for the whole hold. result_ready clears at the edge the new start is sampled.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared constants, state encoding and bit-twiddling helpers for the SIMON32/64 engine.
package simon_pkg;

  localparam logic [61:0] Z0      = 62'b11111010001001010110000111001101111101000100101011000011100110;
  localparam logic [15:0] C_CONST = 16'hFFFC;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    RUN,
    DONE
  } state_t;

  function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] v, input int unsigned n);
    return (v >> n) | (v << (16 - n));
  endfunction

  function automatic logic [15:0] simon_f(input logic [15:0] v);
    return (rotl16(v, 1) & rotl16(v, 8)) ^ rotl16(v, 2);
  endfunction

  // Z0 is written first-bit-leftmost, so sequence bit j sits at position 61-j.
  function automatic logic z_bit(input logic [4:0] j);
    logic [61:0] z;
    z = Z0;
    return z[6'd61 - {1'b0, j}];
  endfunction

endpackage

// File: rtl/simon_round.sv
// One SIMON32 Feistel round, forward or inverse, purely combinational.
module simon_round
  import simon_pkg::*;
(
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] k,
  input  logic        enc,
  output logic [15:0] x_next,
  output logic [15:0] y_next
);

  always_comb begin
    x_next = '0;
    y_next = '0;
    if (enc) begin
      x_next = y ^ simon_f(x) ^ k;
      y_next = x;
    end else begin
      x_next = y;
      y_next = x ^ simon_f(y) ^ k;
    end
  end

endmodule

// File: rtl/simon_seq.sv
// Iterative SIMON32/64 sequencer: key expansion into a local store, then 32 rounds
// forward or in reverse key order, with an optional cache that skips re-expansion.
module simon_seq
  import simon_pkg::*;
#(
  parameter int unsigned ROUNDS    = 32,
  parameter bit          KEY_CACHE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cryp_decryp,
  input  logic [7:0] k_in [7:0],
  input  logic [7:0] text_in [3:0],
  output logic [7:0] crypt_out [3:0],
  output logic       result_ready,
  output logic       busy
);

  localparam logic [4:0] LAST = 5'(ROUNDS - 1);

  state_t      state, state_next;
  logic [15:0] x, y;
  logic        enc;
  logic [63:0] key_reg, key_in;
  logic        cache_valid;
  logic [4:0]  idx, rc;
  logic [31:0] result;
  logic [15:0] key_store [32];

  logic        accept, hit, last_round;
  logic [15:0] t, new_key, x_next, y_next;

  always_comb key_in = {k_in[7], k_in[6], k_in[5], k_in[4],
                        k_in[3], k_in[2], k_in[1], k_in[0]};

  assign accept     = start && (state == IDLE || state == DONE);
  assign hit        = KEY_CACHE && cache_valid && (key_in == key_reg);
  assign last_round = enc ? (rc == LAST) : (rc == '0);

  always_comb begin
    t       = rotr16(key_store[idx - 5'd1], 3) ^ key_store[idx - 5'd3];
    new_key = C_CONST ^ {15'd0, z_bit(idx - 5'd4)} ^ key_store[idx - 5'd4] ^ t ^ rotr16(t, 1);
  end

  simon_round u_round (
    .x      (x),
    .y      (y),
    .k      (key_store[rc]),
    .enc    (enc),
    .x_next (x_next),
    .y_next (y_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_next = hit ? RUN : EXPAND;
      EXPAND: begin
        busy = 1'b1;
        if (idx == LAST) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_round) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Store is not reset; a reset clears cache_valid so partial contents are never trusted.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_store[0] <= key_in[15:0];
      key_store[1] <= key_in[31:16];
      key_store[2] <= key_in[47:32];
      key_store[3] <= key_in[63:48];
    end else if (state == EXPAND) begin
      key_store[idx] <= new_key;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x            <= '0;
      y            <= '0;
      enc          <= 1'b0;
      key_reg      <= '0;
      cache_valid  <= 1'b0;
      idx          <= '0;
      rc           <= '0;
      result       <= '0;
      result_ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x            <= {text_in[3], text_in[2]};
            y            <= {text_in[1], text_in[0]};
            enc          <= cryp_decryp;
            key_reg      <= key_in;
            cache_valid  <= hit;
            idx          <= 5'd4;
            rc           <= cryp_decryp ? '0 : LAST;
            result_ready <= 1'b0;
          end
        end
        EXPAND: begin
          idx <= idx + 5'd1;
          if (idx == LAST) cache_valid <= 1'b1;
        end
        RUN: begin
          x  <= x_next;
          y  <= y_next;
          rc <= enc ? rc + 5'd1 : rc - 5'd1;
          if (last_round) begin
            result       <= {x_next, y_next};
            result_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign crypt_out[3] = result[31:24];
  assign crypt_out[2] = result[23:16];
  assign crypt_out[1] = result[15:8];
  assign crypt_out[0] = result[7:0];

endmodule
